// File: rtl/vga_pkg.sv
// Shared constants for the VGA drawing path: screen geometry, colour key,
// blitter mode bit positions and blitter state encoding.
package vga_pkg;
  localparam int VGA_SCREEN_W = 160;
  localparam int VGA_SCREEN_H = 120;
  localparam int VGA_X_W      = 8;
  localparam int VGA_Y_W      = 7;
  localparam int VGA_COLOR_W  = 3;
  localparam logic [VGA_COLOR_W-1:0] VGA_KEY_COLOR = 3'b111;

  localparam int MODE_HFLIP  = 0;
  localparam int MODE_ERASE  = 1;
  localparam int MODE_TRANSP = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_t;
endpackage

// File: rtl/sprite_blitter_if.sv
// Blitter bus: game-FSM command handshake, sprite ROM port and pixel-write port.
interface sprite_blitter_if #(
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ADDR_W  = 11,
  parameter int COLOR_W = 3
);
  logic               start;
  logic [X_W-1:0]     x0;
  logic [Y_W-1:0]     y0;
  logic [2:0]         mode;
  logic               busy;
  logic               done;
  logic [ADDR_W-1:0]  rom_addr;
  logic [COLOR_W-1:0] rom_data;
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [COLOR_W-1:0] color;
  logic               plot;

  modport master (output start, x0, y0, mode, rom_data,
                  input  busy, done, rom_addr, x, y, color, plot);
  modport slave  (input  start, x0, y0, mode, rom_data,
                  output busy, done, rom_addr, x, y, color, plot);
endinterface

// File: rtl/blit_addr_gen.sv
// Sprite scan counters: walks (cx,cy) row-major and produces the registered ROM
// address as row base plus (optionally mirrored) column offset.
module blit_addr_gen #(
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 11,
  parameter int CX_W     = 6,
  parameter int CY_W     = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_init,
  input  logic              i_hflip,
  input  logic              i_step,
  output logic [CX_W-1:0]   o_cx,
  output logic [CY_W-1:0]   o_cy,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic              r_hflip;
  logic [CX_W-1:0]   r_cx;
  logic [CY_W-1:0]   r_cy;
  logic [ADDR_W-1:0] r_row_base;
  logic [ADDR_W-1:0] r_addr;

  logic              w_row_end;
  logic [CX_W-1:0]   w_cx_nxt;
  logic [CY_W-1:0]   w_cy_nxt;
  logic [ADDR_W-1:0] w_base_nxt;
  logic [ADDR_W-1:0] w_col_nxt;

  assign w_row_end  = (r_cx == CX_W'(SPRITE_W-1));
  assign w_cx_nxt   = w_row_end ? '0 : r_cx + CX_W'(1);
  assign w_cy_nxt   = w_row_end ? r_cy + CY_W'(1) : r_cy;
  assign w_base_nxt = w_row_end ? r_row_base + ADDR_W'(SPRITE_W) : r_row_base;
  // Mirrored column reads the row right-to-left; the row base is unaffected.
  assign w_col_nxt  = r_hflip ? ADDR_W'(SPRITE_W-1) - ADDR_W'(w_cx_nxt)
                              : ADDR_W'(w_cx_nxt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hflip    <= 1'b0;
      r_cx       <= '0;
      r_cy       <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
    end else if (i_init) begin
      r_hflip    <= i_hflip;
      r_cx       <= '0;
      r_cy       <= '0;
      r_row_base <= '0;
      r_addr     <= i_hflip ? ADDR_W'(SPRITE_W-1) : '0;
    end else if (i_step) begin
      r_cx       <= w_cx_nxt;
      r_cy       <= w_cy_nxt;
      r_row_base <= w_base_nxt;
      r_addr     <= w_base_nxt + w_col_nxt;
    end
  end

  assign o_cx   = r_cx;
  assign o_cy   = r_cy;
  assign o_addr = r_addr;
  assign o_last = w_row_end && (r_cy == CY_W'(SPRITE_H-1));
endmodule

// File: rtl/sprite_blitter.sv
// Copies a SPRITE_W x SPRITE_H image from a synchronous ROM to the VGA pixel
// port at a latched origin, with hflip, colour-key, erase and screen clipping.
module sprite_blitter
  import vga_pkg::*;
#(
  parameter int SCREEN_W = VGA_SCREEN_W,
  parameter int SCREEN_H = VGA_SCREEN_H,
  parameter int X_W      = VGA_X_W,
  parameter int Y_W      = VGA_Y_W,
  parameter int SPRITE_W = 40,
  parameter int SPRITE_H = 40,
  parameter int ADDR_W   = 11,
  parameter int COLOR_W  = VGA_COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = VGA_KEY_COLOR
) (
  input logic             clk,
  input logic             reset,
  sprite_blitter_if.slave bif
);
  localparam int CX_W   = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int CY_W   = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;
  localparam int STAGES = 1;

  blit_state_t        r_state;
  logic [X_W-1:0]     r_x0;
  logic [Y_W-1:0]     r_y0;
  logic [2:0]         r_mode;
  logic [STAGES:0]    r_vld_pipe;
  logic [CX_W-1:0]    r_cx1;
  logic [CY_W-1:0]    r_cy1;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;
  logic [COLOR_W-1:0] r_color;
  logic               r_plot;

  logic [CX_W-1:0]    w_cx;
  logic [CY_W-1:0]    w_cy;
  logic [ADDR_W-1:0]  w_addr;
  logic               w_last;
  logic               w_accept;
  logic               w_step;
  logic [X_W:0]       w_sx;
  logic [Y_W:0]       w_sy;
  logic               w_vis;
  logic               w_key;

  assign w_accept = (r_state == ST_IDLE) && bif.start;
  assign w_step   = (r_state == ST_FETCH) && !w_last;

  blit_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .ADDR_W   (ADDR_W),
    .CX_W     (CX_W),
    .CY_W     (CY_W)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .i_init  (w_accept),
    .i_hflip (bif.mode[MODE_HFLIP]),
    .i_step  (w_step),
    .o_cx    (w_cx),
    .o_cy    (w_cy),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_x0    <= '0;
      r_y0    <= '0;
      r_mode  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bif.start) begin
          r_x0    <= bif.x0;
          r_y0    <= bif.y0;
          r_mode  <= bif.mode;
          r_state <= ST_FETCH;
        end
        ST_FETCH: if (w_last) r_state <= ST_DRAIN;
        ST_DRAIN: if (r_vld_pipe == '0) r_state <= ST_DONE;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Bit 0: rom_addr holds a live pixel address; bit 1: rom_data is live.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_cx1      <= '0;
      r_cy1      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_accept | w_step};
      if (r_vld_pipe[0]) begin
        r_cx1 <= w_cx;
        r_cy1 <= w_cy;
      end
    end
  end

  // One extra bit so off-screen pixels compare large instead of wrapping to 0.
  assign w_sx  = (X_W+1)'(r_x0) + (X_W+1)'(r_cx1);
  assign w_sy  = (Y_W+1)'(r_y0) + (Y_W+1)'(r_cy1);
  assign w_vis = (w_sx < (X_W+1)'(SCREEN_W)) && (w_sy < (Y_W+1)'(SCREEN_H));
  assign w_key = r_mode[MODE_TRANSP] & ~r_mode[MODE_ERASE] &
                 (bif.rom_data == KEY_COLOR);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_plot  <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_color <= '0;
    end else begin
      r_plot <= r_vld_pipe[STAGES] & w_vis & ~w_key;
      if (r_vld_pipe[STAGES]) begin
        r_x     <= w_sx[X_W-1:0];
        r_y     <= w_sy[Y_W-1:0];
        r_color <= r_mode[MODE_ERASE] ? '0 : bif.rom_data;
      end
    end
  end

  assign bif.rom_addr = w_addr;
  assign bif.busy     = (r_state != ST_IDLE);
  assign bif.done     = (r_state == ST_DONE);
  assign bif.x        = r_x;
  assign bif.y        = r_y;
  assign bif.color    = r_color;
  assign bif.plot     = r_plot;
endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised rectangle blitter for the VGA drawing path. It copies a `SPRITE_W`×`SPRITE_H` image from an external synchronous ROM to the VGA adapter's pixel-write port at a programmable origin. It supports horizontal flip, colour-key transparency, solid-black erase and screen clipping. It replaces hand-sequenced per-screen x/y/address counter control: the game FSM issues one `start` per image and waits for `done`.

## Interface

**Parameters**
- `SCREEN_W`, default 160: visible columns.
- `SCREEN_H`, default 120: visible rows.
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `SPRITE_W`, default 40: image width in pixels, ≥1.
- `SPRITE_H`, default 40: image height in pixels, ≥1.
- `ADDR_W`, default 11: ROM address width. Requires 2^ADDR_W ≥ SPRITE_W·SPRITE_H.
- `COLOR_W`, default 3: pixel colour width.
- `KEY_COLOR`, default 3'b111: transparent colour key.

**Ports**
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a blit; accepted only while `busy`=0.
- `x0` in X_W: origin column, sampled on accepted `start`.
- `y0` in Y_W: origin row, sampled on accepted `start`.
- `mode` in 3: [0] hflip, [1] erase (solid colour 0), [2] transparency enable. Sampled on accepted `start`.
- `busy` out 1: high from the cycle after an accepted `start` through the `done` cycle.
- `done` out 1: one-cycle pulse when the blit completes.
- `rom_addr` out ADDR_W: registered ROM address.
- `rom_data` in COLOR_W: ROM output, valid one cycle after `rom_addr`.
- `x` out X_W: pixel column, registered.
- `y` out Y_W: pixel row, registered.
- `color` out COLOR_W: pixel colour, registered.
- `plot` out 1: pixel write strobe, registered.

## Operation

**States:** IDLE → FETCH → DRAIN → DONE → IDLE.
- **IDLE:** `start`=1 latches `x0`, `y0`, `mode`. Sets `cx`=0, `cy`=0 and `rom_addr` = (hflip ? SPRITE_W−1 : 0). Next state FETCH.
- **FETCH:** each cycle presents the address for pixel (`cx`,`cy`) and pushes a valid token with (`cx`,`cy`) into stage 1.
  - `cx` increments; when `cx`=SPRITE_W−1 it wraps to 0 and `cy` increments.
  - After the token for (SPRITE_W−1, SPRITE_H−1), next state DRAIN.
- **Addressing:** address = `cy`·SPRITE_W + (hflip ? SPRITE_W−1−`cx` : `cx`). Kept as a row-base register plus column offset; no multiplier.
- **DRAIN:** waits until both pipeline valids are clear, then moves to DONE.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Pixel output** for a stage-1 token:
  - Sx = x0+cx and Sy = y0+cy, computed one bit wider than X_W/Y_W.
  - `plot`=1 iff Sx<SCREEN_W, Sy<SCREEN_H, and not (mode[2] & !mode[1] & `rom_data`==KEY_COLOR).
  - `color` = mode[1] ? 0 : `rom_data`.
  - `x`/`y` = truncated Sx/Sy.
- **Clipping:** off-screen pixels are dropped and never wrap to column or row 0. Each blit still takes exactly SPRITE_W·SPRITE_H fetch cycles.
- **`start` while `busy`:** ignored, with no effect on the latched origin or mode.
- **`reset`**, including mid-blit: state IDLE; `busy`, `done`, `plot` = 0; `x`, `y`, `color`, `rom_addr` = 0; pipeline valids cleared. No further pixels are emitted.

## Timing

- `start` sampled at edge E0. `busy`=1 and `rom_addr` for pixel 0 are valid in cycle 1.
- Pixel k address is in cycle 1+k. `rom_data` is valid in cycle 2+k. `x`/`y`/`color`/`plot` for pixel k are valid in cycle 3+k.
- Last pixel N−1 (N = SPRITE_W·SPRITE_H) appears in cycle N+2. `done`=1 in cycle N+3, `busy` falls in cycle N+4.
- Minimum `start`-to-`start` spacing is N+4 cycles. `start` may be held high: it is re-accepted in the first IDLE cycle.
- `plot` is never high outside `busy`. It is high for at most one cycle per pixel, with no gaps between consecutive visible pixels.

## Structure

- Shared package `vga_pkg`:
  - screen dimensions, coordinate and colour widths;
  - `KEY_COLOR`;
  - mode bit index constants `MODE_HFLIP`, `MODE_ERASE`, `MODE_TRANSP`;
  - state enum.
- One sub-module `blit_addr_gen`: the `cx`/`cy`/row-base counters and flip addressing, with a `last` flag output. The FSM, pipeline and clip/key logic stay in the top module.
- ROM multiplexing for different images remains outside this block.

## Test plan

- **Basic blit:** SPRITE 4×3, ROM[i]=i mod 8, `start` with x0=10, y0=20, mode=0.
  - 12 `plot` pulses in cycles 3–14, row-major from (10,20) to (13,22), with color=i mod 8.
  - `done` in cycle 15.
- **Flip and erase:** mode=001 → row 0 colours 3,2,1,0. mode=010 → all 12 pixels plotted with color=0.
- **Transparency:** ROM pixels 5 and 7 = 3'b111, mode=100 → 10 plots, pixels 5 and 7 missing, `done` timing unchanged. With mode=110, all 12 plotted.
- **Clipping:** x0=158, y0=119 with 4×3 → only (158,119) and (159,119) plotted, no wrap to x=0. `done` still in cycle 15.
- **Handshake and reset:**
  - `start` pulsed during `busy` → ignored, origin unchanged.
  - `start` held high → back-to-back blits spaced 16 cycles.
  - `reset` in cycle 6 → `plot`/`busy`/`done`=0 next cycle, and no pixel emitted afterwards.
